pkg_read_ctrl: RTL and testbench
================================

PKG_READ_CTRL -- requirements
Module: pkg_read_ctrl

Parameters
REQ-001 DATA_WIDTH, default 8, width of FIFO read data and host byte.
REQ-002 PACKAGE_SIZE, default 11552, bytes per package; one package occupies one ping-pong bank.
REQ-003 CNT_WIDTH, default 14, width of the byte counter; must satisfy 2^CNT_WIDTH > PACKAGE_SIZE.
REQ-004 INTR_HOLD, default 16, sys_clk cycles that intr_out stays high per package.
REQ-005 CS_TIMEOUT, default 65535, sys_clk cycles to wait for host_cs after the interrupt.

Interface
REQ-006 sys_clk  in  1  single clock; all logic is on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 package_ready  in  1  level from the ping-pong FIFO; high while a bank is full.
REQ-009 fifo_dout  in  DATA_WIDTH  FIFO read data.
REQ-010 fifo_valid  in  1  qualifies fifo_dout; arrives 1 cycle after fifo_rd_en.
REQ-011 fifo_rd_en  out  1  one-cycle read strobe to the FIFO.
REQ-012 host_cs  in  1  ESP32 chip-select, synchronised, active-high.
REQ-013 host_byte_req  in  1  one-cycle pulse; host requests the next byte.
REQ-014 tx_data / tx_valid  out  DATA_WIDTH / 1  byte to the SPI shifter plus one-cycle qualifier.
REQ-015 intr_out  out  1  interrupt to the ESP32.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 pkg_done  out  1  one-cycle pulse when a full package has been transferred.
REQ-018 err_abort, err_timeout  out  1 each  one-cycle error pulses.
REQ-019 overrun_cnt  out  8  saturating count of packages lost.

Function
REQ-020 The design shall have the FSM states IDLE, INTR, WAIT_CS, READ, DONE.
REQ-021 The design shall edge-detect package_ready: pkg_evt = package_ready & ~package_ready_d.
REQ-022 In IDLE, pkg_evt or a set pending flag shall move the FSM to INTR and clear pending.
REQ-023 In INTR, intr_out shall be high for exactly INTR_HOLD cycles, then the FSM shall go to WAIT_CS.
REQ-024 In WAIT_CS, host_cs=1 shall move the FSM to READ with byte_cnt=0.
REQ-025 If host_cs stays low for CS_TIMEOUT cycles in WAIT_CS, the block shall pulse err_timeout and return to IDLE.
REQ-026 In READ, host_byte_req with no read outstanding shall assert fifo_rd_en for exactly 1 cycle and set outstanding.
REQ-027 host_byte_req with a read outstanding shall be ignored and shall not be queued.
REQ-028 fifo_valid shall clear outstanding and drive tx_data=fifo_dout and tx_valid=1 in the same cycle.
REQ-029 fifo_valid shall increment byte_cnt.
REQ-030 When byte_cnt reaches PACKAGE_SIZE on a fifo_valid, the FSM shall go to DONE and pulse pkg_done.
REQ-031 After byte_cnt reaches PACKAGE_SIZE, no further fifo_rd_en shall be issued.
REQ-032 In DONE, the FSM shall wait for host_cs=0, then go to IDLE.
REQ-033 host_cs falling in READ before PACKAGE_SIZE bytes shall pulse err_abort and go to IDLE.
REQ-034 An aborted package shall be discarded, the read shall not resume, and byte_cnt shall clear.
REQ-035 A fifo_valid arriving in the cycle after an abort shall be dropped (tx_valid=0).
REQ-036 pkg_evt in any state other than IDLE shall set pending if pending is clear.
REQ-037 pkg_evt while pending is already set shall increment overrun_cnt, saturating at 255.
REQ-038 pkg_evt in the same cycle as DONE->IDLE shall set pending, so the FSM enters INTR on the next cycle.
REQ-039 fifo_rd_en shall never be asserted outside READ.
REQ-040 intr_out shall never be asserted outside INTR.

Reset
REQ-041 rst=1 shall force state=IDLE and clear byte_cnt, pending, outstanding, package_ready_d and overrun_cnt.
REQ-042 rst=1 shall drive all outputs to 0, including mid-package; the transfer is abandoned and no error pulse is issued.

Verification
REQ-043 Normal package: INTR_HOLD=4, PACKAGE_SIZE=8; package_ready rises, host_cs rises, 8 spaced host_byte_req -> intr_out high exactly 4 cycles; 8 fifo_rd_en; tx_data matches the FIFO bytes 0x00..0x07; one pkg_done; FSM back in IDLE after host_cs falls.
REQ-044 Back-to-back request: second host_byte_req 1 cycle after the first -> only one fifo_rd_en; byte_cnt advances by 1.
REQ-045 Overrun: two further package_ready rising edges during READ -> pending set, overrun_cnt=1; second INTR immediately after DONE->IDLE.
REQ-046 Abort: host_cs drops after 3 bytes -> err_abort pulse; late fifo_valid gives no tx_valid; IDLE; byte_cnt=0.
REQ-047 Timeout: CS_TIMEOUT=10, host_cs held low -> err_timeout exactly 10 cycles after entering WAIT_CS; IDLE.
REQ-048 Reset mid-READ: rst at byte 5 -> next cycle all outputs 0, overrun_cnt=0, state IDLE.

Source files
------------

// File: rtl/pkg_read_ctrl.sv
// Package read controller: raises an interrupt per full ping-pong bank and
// streams the bank to the SPI shifter one host-requested byte at a time.
module pkg_read_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int PACKAGE_SIZE = 11552,
    parameter int CNT_WIDTH    = 14,
    parameter int INTR_HOLD    = 16,
    parameter int CS_TIMEOUT   = 65535
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  package_ready,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    output logic                  fifo_rd_en,
    input  logic                  host_cs,
    input  logic                  host_byte_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  intr_out,
    output logic                  busy,
    output logic                  pkg_done,
    output logic                  err_abort,
    output logic                  err_timeout,
    output logic [7:0]            overrun_cnt
);

    localparam int HW = (INTR_HOLD > 1) ? $clog2(INTR_HOLD) : 1;
    localparam int TW = (CS_TIMEOUT > 1) ? $clog2(CS_TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(INTR_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(CS_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BYTE = CNT_WIDTH'(PACKAGE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        INTR,
        WAIT_CS,
        READ,
        DONE
    } state_t;

    state_t               state;
    logic                 package_ready_d;
    logic                 pending;
    logic                 outstanding;
    logic [CNT_WIDTH-1:0] byte_cnt;
    logic [HW-1:0]        hold_cnt;
    logic [TW-1:0]        to_cnt;
    logic                 pkg_evt;

    assign pkg_evt = package_ready & ~package_ready_d;
    assign busy    = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state           <= IDLE;
            package_ready_d <= 1'b0;
            pending         <= 1'b0;
            outstanding     <= 1'b0;
            byte_cnt        <= '0;
            hold_cnt        <= '0;
            to_cnt          <= '0;
            fifo_rd_en      <= 1'b0;
            tx_data         <= '0;
            tx_valid        <= 1'b0;
            intr_out        <= 1'b0;
            pkg_done        <= 1'b0;
            err_abort       <= 1'b0;
            err_timeout     <= 1'b0;
            overrun_cnt     <= '0;
        end else begin
            package_ready_d <= package_ready;
            fifo_rd_en      <= 1'b0;
            tx_valid        <= 1'b0;
            pkg_done        <= 1'b0;
            err_abort       <= 1'b0;
            err_timeout     <= 1'b0;

            // A new bank while one is already queued means a lost package
            if (pkg_evt && pending && overrun_cnt != 8'hff)
                overrun_cnt <= overrun_cnt + 8'd1;
            if (pkg_evt && state != IDLE)
                pending <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (pkg_evt || pending) begin
                        state    <= INTR;
                        pending  <= 1'b0;
                        intr_out <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                INTR: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= WAIT_CS;
                        intr_out <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                WAIT_CS: begin
                    if (host_cs) begin
                        state       <= READ;
                        byte_cnt    <= '0;
                        outstanding <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                READ: begin
                    // Deselect wins: the host can no longer clock out a byte
                    if (!host_cs) begin
                        state       <= IDLE;
                        err_abort   <= 1'b1;
                        byte_cnt    <= '0;
                        outstanding <= 1'b0;
                    end else if (fifo_valid && outstanding) begin
                        tx_data     <= fifo_dout;
                        tx_valid    <= 1'b1;
                        outstanding <= 1'b0;
                        byte_cnt    <= byte_cnt + CNT_WIDTH'(1);
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= DONE;
                            pkg_done <= 1'b1;
                        end
                    end else if (host_byte_req && !outstanding) begin
                        fifo_rd_en  <= 1'b1;
                        outstanding <= 1'b1;
                    end
                end
                DONE: begin
                    if (!host_cs) begin
                        state    <= IDLE;
                        byte_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkg_read_ctrl.sv
// Bench for pkg_read_ctrl: FIFO and host models drive packages, a monitor
// logs output activity and each scenario checks it against expected streams.
module tb_pkg_read_ctrl;

    localparam int DW = 8;
    localparam int PS = 8;
    localparam int CW = 14;
    localparam int IH = 4;
    localparam int CT = 10;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          package_ready;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_valid = 1'b0;
    logic          fifo_rd_en;
    logic          host_cs;
    logic          host_byte_req;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          intr_out;
    logic          busy;
    logic          pkg_done;
    logic          err_abort;
    logic          err_timeout;
    logic [7:0]    overrun_cnt;

    int tests = 0;
    int fails = 0;

    int rd_cnt, val_cnt, intr_cnt, done_cnt, abort_cnt, tmo_cnt;
    logic [7:0] tx_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    pkg_read_ctrl #(
        .DATA_WIDTH  (DW),
        .PACKAGE_SIZE(PS),
        .CNT_WIDTH   (CW),
        .INTR_HOLD   (IH),
        .CS_TIMEOUT  (CT)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .package_ready(package_ready),
        .fifo_dout    (fifo_dout),
        .fifo_valid   (fifo_valid),
        .fifo_rd_en   (fifo_rd_en),
        .host_cs      (host_cs),
        .host_byte_req(host_byte_req),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .intr_out     (intr_out),
        .busy         (busy),
        .pkg_done     (pkg_done),
        .err_abort    (err_abort),
        .err_timeout  (err_timeout),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO bank: data appears the cycle after a read strobe
    always @(posedge sys_clk) begin
        fifo_valid <= 1'b0;
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_valid <= 1'b1;
            fifo_dout  <= fifo_q.pop_front();
        end
    end

    always @(posedge sys_clk) begin
        #1;
        if (fifo_rd_en)  rd_cnt++;
        if (fifo_valid)  val_cnt++;
        if (tx_valid)    tx_q.push_back(tx_data);
        if (intr_out)    intr_cnt++;
        if (pkg_done)    done_cnt++;
        if (err_abort)   abort_cnt++;
        if (err_timeout) tmo_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clr();
        rd_cnt = 0; val_cnt = 0; intr_cnt = 0;
        done_cnt = 0; abort_cnt = 0; tmo_cnt = 0;
        tx_q.delete();
    endtask

    task automatic load_pkg(input bit rnd);
        logic [7:0] b;
        exp_q.delete();
        fifo_q.delete();
        for (int i = 0; i < PS; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            exp_q.push_back(b);
            fifo_q.push_back(b);
        end
    endtask

    task automatic wait_cs_phase(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (intr_cnt > 0 && !intr_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_byte(input bit dbl, input int gap);
        host_byte_req = 1'b1;
        tick(1);
        if (dbl) tick(1);
        host_byte_req = 1'b0;
        tick(gap);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic bit stream_ok();
        if (tx_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i])
            if (tx_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        package_ready = 1'b0;
        host_cs = 1'b0;
        host_byte_req = 1'b0;
        tick(3);
        tests++;
        if ({fifo_rd_en, tx_valid, intr_out, busy, pkg_done,
             err_abort, err_timeout} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {fifo_rd_en, tx_valid, intr_out, busy,
                      pkg_done, err_abort, err_timeout});
        end
        tests++;
        if (tx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_tx_data: got %h required 00", tx_data);
        end
        tests++;
        if (overrun_cnt !== 8'h00) begin
            fails++;
            $display("FAIL reset_overrun: got %0d required 0", overrun_cnt);
        end
        rst = 1'b0;
        tick(2);
        clr();
    endtask

    task automatic test_normal();
        bit ok;
        clr();
        load_pkg(1'b0);
        package_ready = 1'b1;
        wait_cs_phase(ok);
        host_cs = 1'b1;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL normal_wait_cs: intr phase never ended");
        end
        tests++;
        if (intr_cnt != IH) begin
            fails++;
            $display("FAIL normal_intr_len: got %0d required %0d",
                     intr_cnt, IH);
        end
        tick(1);
        for (int i = 0; i < PS; i++) send_byte(1'b0, 3);
        wait_done(ok);
        host_cs = 1'b0;
        package_ready = 1'b0;
        tick(3);
        tests++;
        if (!ok || done_cnt != 1) begin
            fails++;
            $display("FAIL normal_done: got %0d pulses required 1", done_cnt);
        end
        tests++;
        if (rd_cnt != PS) begin
            fails++;
            $display("FAIL normal_rd: got %0d required %0d", rd_cnt, PS);
        end
        tests++;
        if (!stream_ok()) begin
            fails++;
            $display("FAIL normal_data: got %0d bytes, required %0d bytes 00..07",
                     tx_q.size(), exp_q.size());
        end
        tests++;
        if (busy !== 1'b0 || abort_cnt != 0 || tmo_cnt != 0) begin
            fails++;
            $display("FAIL normal_idle: busy=%b abort=%0d tmo=%0d required 0/0/0",
                     busy, abort_cnt, tmo_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clr();
        load_pkg(1'b1);
        package_ready = 1'b1;
        wait_cs_phase(ok);
        host_cs = 1'b1;
        tick(1);
        send_byte(1'b1, 4);
        tests++;
        if (rd_cnt != 1 || tx_q.size() != 1) begin
            fails++;
            $display("FAIL b2b_single: rd=%0d tx=%0d required 1/1",
                     rd_cnt, tx_q.size());
        end
        for (int i = 1; i < PS; i++) send_byte(1'b0, 3);
        wait_done(ok);
        host_cs = 1'b0;
        package_ready = 1'b0;
        tick(3);
        tests++;
        if (!ok || rd_cnt != PS || !stream_ok()) begin
            fails++;
            $display("FAIL b2b_stream: rd=%0d tx=%0d required %0d/%0d",
                     rd_cnt, tx_q.size(), PS, PS);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int p = 0; p < 4; p++) begin
            clr();
            load_pkg(1'b1);
            package_ready = 1'b1;
            wait_cs_phase(ok);
            host_cs = 1'b1;
            tick(1);
            for (int i = 0; i < PS; i++)
                send_byte(1'($urandom), int'($urandom_range(2, 6)));
            wait_done(ok);
            host_cs = 1'b0;
            package_ready = 1'b0;
            tick(3);
            tests++;
            if (!ok || done_cnt != 1 || rd_cnt != PS || !stream_ok()) begin
                fails++;
                $display("FAIL random_pkg%0d: done=%0d rd=%0d tx=%0d required 1/%0d/%0d",
                         p, done_cnt, rd_cnt, tx_q.size(), PS, PS);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        clr();
        load_pkg(1'b1);
        package_ready = 1'b1;
        wait_cs_phase(ok);
        host_cs = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) send_byte(1'b0, 3);
        host_byte_req = 1'b1;
        tick(1);
        host_byte_req = 1'b0;
        host_cs = 1'b0;
        tick(4);
        tests++;
        if (abort_cnt != 1) begin
            fails++;
            $display("FAIL abort_pulse: got %0d required 1", abort_cnt);
        end
        tests++;
        if (val_cnt != 4 || tx_q.size() != 3) begin
            fails++;
            $display("FAIL abort_late_valid: valid=%0d tx=%0d required 4/3",
                     val_cnt, tx_q.size());
        end
        tests++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            fails++;
            $display("FAIL abort_idle: busy=%b done=%0d required 0/0",
                     busy, done_cnt);
        end
        package_ready = 1'b0;
        tick(2);
        clr();
        load_pkg(1'b1);
        package_ready = 1'b1;
        wait_cs_phase(ok);
        host_cs = 1'b1;
        tick(1);
        for (int i = 0; i < PS - 1; i++) send_byte(1'b0, 3);
        tests++;
        if (done_cnt != 0) begin
            fails++;
            $display("FAIL abort_restart_early: done=%0d required 0", done_cnt);
        end
        send_byte(1'b0, 3);
        wait_done(ok);
        host_cs = 1'b0;
        package_ready = 1'b0;
        tick(3);
        tests++;
        if (!ok || done_cnt != 1 || !stream_ok()) begin
            fails++;
            $display("FAIL abort_restart: done=%0d tx=%0d required 1/%0d",
                     done_cnt, tx_q.size(), PS);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k;
        clr();
        package_ready = 1'b1;
        wait_cs_phase(ok);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            k++;
            if (err_timeout) break;
        end
        tests++;
        if (!ok || k != CT || tmo_cnt != 1) begin
            fails++;
            $display("FAIL timeout_delay: got %0d cycles pulses=%0d required %0d/1",
                     k, tmo_cnt, CT);
        end
        tick(1);
        tests++;
        if (busy !== 1'b0 || rd_cnt != 0) begin
            fails++;
            $display("FAIL timeout_idle: busy=%b rd=%0d required 0/0",
                     busy, rd_cnt);
        end
        package_ready = 1'b0;
        tick(2);
    endtask

    task automatic test_overrun();
        bit ok;
        int k;
        clr();
        load_pkg(1'b1);
        package_ready = 1'b1;
        wait_cs_phase(ok);
        host_cs = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) send_byte(1'b0, 3);
        package_ready = 1'b0; tick(2);
        package_ready = 1'b1; tick(2);
        package_ready = 1'b0; tick(2);
        package_ready = 1'b1; tick(2);
        tests++;
        if (overrun_cnt !== 8'd1) begin
            fails++;
            $display("FAIL overrun_cnt: got %0d required 1", overrun_cnt);
        end
        for (int i = 3; i < PS; i++) send_byte(1'b0, 3);
        wait_done(ok);
        host_cs = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            k++;
            if (intr_out) break;
        end
        tests++;
        if (!ok || k != 2 || !stream_ok()) begin
            fails++;
            $display("FAIL overrun_reintr: got %0d cycles required 2", k);
        end
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (tmo_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        tick(1);
        tests++;
        if (!ok || busy !== 1'b0 || rd_cnt != PS) begin
            fails++;
            $display("FAIL overrun_pending_pkg: busy=%b rd=%0d required 0/%0d",
                     busy, rd_cnt, PS);
        end
        package_ready = 1'b0;
        tick(2);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr();
        load_pkg(1'b1);
        package_ready = 1'b1;
        wait_cs_phase(ok);
        host_cs = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) send_byte(1'b0, 3);
        host_byte_req = 1'b1;
        tick(1);
        host_byte_req = 1'b0;
        rst = 1'b1;
        package_ready = 1'b0;
        host_cs = 1'b0;
        tick(1);
        tests++;
        if ({fifo_rd_en, tx_valid, intr_out, busy, pkg_done,
             err_abort, err_timeout} !== 7'b0 || tx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b/%h required 0000000/00",
                     {fifo_rd_en, tx_valid, intr_out, busy,
                      pkg_done, err_abort, err_timeout}, tx_data);
        end
        tests++;
        if (overrun_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_overrun: got %0d required 0", overrun_cnt);
        end
        tick(1);
        rst = 1'b0;
        fifo_q.delete();
        tick(4);
        tests++;
        if (!ok || abort_cnt != 0 || tmo_cnt != 0 || busy !== 1'b0
            || tx_q.size() != 4) begin
            fails++;
            $display("FAIL reset_mid_quiet: abort=%0d tmo=%0d busy=%b tx=%0d required 0/0/0/4",
                     abort_cnt, tmo_cnt, busy, tx_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        package_ready = 1'b0;
        host_cs = 1'b0;
        host_byte_req = 1'b0;
        clr();
        test_reset();
        test_normal();
        test_back_to_back();
        test_random();
        test_abort();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
